// File: rtl/rename_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | rename_pkg : shared widths, tag/reg types and defaults for rename   |
// | Revision   : 1.0                                                     |
// +--------------------------------------------------------------------+
package rename_pkg;

   localparam int TAG_BITS = 8;
   localparam int REG_BITS = 5;
   localparam int CNT_BITS = 6;

   typedef logic [TAG_BITS-1:0] tag_t;
   typedef logic [REG_BITS-1:0] reg_t;

   localparam tag_t NULL_TAG         = 8'h00;
   localparam reg_t ZERO_REG_DEFAULT = 5'd31;
   localparam int   NUM_TAGS_DEFAULT = 32;

endpackage

`default_nettype wire

// File: rtl/tag_free_list.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tag_free_list : circular tag buffer, 2 pops + 2 pushes per cycle    |
// | Revision      : 1.0                                                  |
// +--------------------------------------------------------------------+
module tag_free_list
   import rename_pkg::*;
#(
   parameter int NUM_TAGS = NUM_TAGS_DEFAULT,
   localparam int IDX_BITS = $clog2(NUM_TAGS)
) (
   input  logic                clock,
   input  logic                reset,
   input  logic [1:0]          pop_cnt,
   output tag_t                pop_tag0,
   output tag_t                pop_tag1,
   input  logic                push1_valid,
   input  tag_t                push1_tag,
   input  logic                push2_valid,
   input  tag_t                push2_tag,
   output logic [CNT_BITS-1:0] count,
   output logic                overflow
);

   tag_t                array_q [NUM_TAGS];
   tag_t                array_d [NUM_TAGS];
   logic [IDX_BITS-1:0] head_q, head_d;
   logic [IDX_BITS-1:0] tail_q, tail_d;
   logic [IDX_BITS-1:0] push2_idx;
   logic [CNT_BITS-1:0] count_q, count_d;
   logic [CNT_BITS-1:0] avail;
   logic [1:0]          push_cnt;
   logic                overflow_q, overflow_d;
   logic                push1_req, push2_req, push1_ok, push2_ok;

   function automatic logic [IDX_BITS-1:0] wrap_add(input logic [IDX_BITS-1:0] ptr,
                                                     input logic [1:0]          n);
      logic [IDX_BITS:0] sum;
      sum = {1'b0, ptr} + (IDX_BITS+1)'(n);
      if (sum >= (IDX_BITS+1)'(NUM_TAGS)) begin
         sum = sum - (IDX_BITS+1)'(NUM_TAGS);
      end
      return sum[IDX_BITS-1:0];
   endfunction

   assign pop_tag0 = array_q[head_q];
   assign pop_tag1 = array_q[wrap_add(head_q, 2'd1)];
   assign count    = count_q;
   assign overflow = overflow_q;

   // Push room is judged after this cycle's pops; pops only read registered entries.
   always_comb begin
      push1_req = push1_valid && (push1_tag != NULL_TAG);
      push2_req = push2_valid && (push2_tag != NULL_TAG);
      avail     = count_q - CNT_BITS'(pop_cnt);
      push1_ok  = push1_req && (avail < CNT_BITS'(NUM_TAGS));
      push2_ok  = push2_req && ((avail + CNT_BITS'(push1_ok)) < CNT_BITS'(NUM_TAGS));
      push_cnt  = 2'(push1_ok) + 2'(push2_ok);
      push2_idx = push1_ok ? wrap_add(tail_q, 2'd1) : tail_q;

      array_d = array_q;
      if (push1_ok) begin
         array_d[tail_q] = push1_tag;
      end
      if (push2_ok) begin
         array_d[push2_idx] = push2_tag;
      end

      head_d     = wrap_add(head_q, pop_cnt);
      tail_d     = wrap_add(tail_q, push_cnt);
      count_d    = avail + CNT_BITS'(push_cnt);
      overflow_d = overflow_q | (push1_req & ~push1_ok) | (push2_req & ~push2_ok);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < NUM_TAGS; i++) begin
            array_q[i] <= TAG_BITS'(i + 1);
         end
         head_q     <= '0;
         tail_q     <= '0;
         count_q    <= CNT_BITS'(NUM_TAGS);
         overflow_q <= 1'b0;
      end else begin
         array_q    <= array_d;
         head_q     <= head_d;
         tail_q     <= tail_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
      end
   end

endmodule

`default_nettype wire

// File: rtl/rename_controller.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | rename_controller : 2-wide dispatch tag allocation and map writes   |
// | Revision          : 1.0                                              |
// +--------------------------------------------------------------------+
module rename_controller
   import rename_pkg::*;
#(
   parameter int   NUM_TAGS = NUM_TAGS_DEFAULT,
   parameter reg_t ZERO_REG = ZERO_REG_DEFAULT
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                disp1_valid,
   input  reg_t                disp1_dest_reg,
   input  logic                disp2_valid,
   input  reg_t                disp2_dest_reg,
   output logic                disp_stall,
   output tag_t                disp1_tag,
   output tag_t                disp2_tag,
   output reg_t                mt_reg1,
   output tag_t                mt_tag1,
   output logic                mt_write1,
   output reg_t                mt_reg2,
   output tag_t                mt_tag2,
   output logic                mt_write2,
   input  logic                free1_valid,
   input  tag_t                free1_tag,
   input  logic                free2_valid,
   input  tag_t                free2_tag,
   output logic [CNT_BITS-1:0] free_count,
   output logic                overflow_err
);

   logic       need1, need2, grant, same_dest;
   logic [1:0] need, pop_cnt;
   tag_t       pop_tag0, pop_tag1;

   tag_free_list #(
      .NUM_TAGS    (NUM_TAGS)
   ) u_free_list (
      .clock       (clock),
      .reset       (reset),
      .pop_cnt     (pop_cnt),
      .pop_tag0    (pop_tag0),
      .pop_tag1    (pop_tag1),
      .push1_valid (free1_valid),
      .push1_tag   (free1_tag),
      .push2_valid (free2_valid),
      .push2_tag   (free2_tag),
      .count       (free_count),
      .overflow    (overflow_err)
   );

   // All-or-nothing grant against the registered count, so same-cycle frees never help.
   always_comb begin
      need1     = disp1_valid && (disp1_dest_reg != ZERO_REG);
      need2     = disp2_valid && (disp2_dest_reg != ZERO_REG);
      need      = 2'(need1) + 2'(need2);
      grant     = !reset && (CNT_BITS'(need) <= free_count);
      same_dest = need1 && need2 && (disp1_dest_reg == disp2_dest_reg);
      pop_cnt   = grant ? need : 2'd0;

      disp_stall = !grant;
      disp1_tag  = (grant && need1) ? pop_tag0 : NULL_TAG;
      disp2_tag  = NULL_TAG;
      if (grant && need2) begin
         disp2_tag = need1 ? pop_tag1 : pop_tag0;
      end

      // Younger slot owns the mapping when both target the same register.
      mt_reg1   = disp1_dest_reg;
      mt_tag1   = disp1_tag;
      mt_write1 = grant && need1 && !same_dest;
      mt_reg2   = disp2_dest_reg;
      mt_tag2   = disp2_tag;
      mt_write2 = grant && need2;
   end

endmodule

`default_nettype wire

// File: tb/tb_rename_controller.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_rename_controller : random + directed bench with queue model     |
// | Revision             : 1.0                                           |
// +--------------------------------------------------------------------+
module tb_rename_controller;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       disp1_valid = 1'b0, disp2_valid = 1'b0;
   logic [4:0] disp1_dest_reg = '0, disp2_dest_reg = '0;
   logic       disp_stall;
   logic [7:0] disp1_tag, disp2_tag, mt_tag1, mt_tag2;
   logic [4:0] mt_reg1, mt_reg2;
   logic       mt_write1, mt_write2;
   logic       free1_valid = 1'b0, free2_valid = 1'b0;
   logic [7:0] free1_tag = '0, free2_tag = '0;
   logic [5:0] free_count;
   logic       overflow_err;

   rename_controller dut (
      .clock          (clock),
      .reset          (reset),
      .disp1_valid    (disp1_valid),
      .disp1_dest_reg (disp1_dest_reg),
      .disp2_valid    (disp2_valid),
      .disp2_dest_reg (disp2_dest_reg),
      .disp_stall     (disp_stall),
      .disp1_tag      (disp1_tag),
      .disp2_tag      (disp2_tag),
      .mt_reg1        (mt_reg1),
      .mt_tag1        (mt_tag1),
      .mt_write1      (mt_write1),
      .mt_reg2        (mt_reg2),
      .mt_tag2        (mt_tag2),
      .mt_write2      (mt_write2),
      .free1_valid    (free1_valid),
      .free1_tag      (free1_tag),
      .free2_valid    (free2_valid),
      .free2_tag      (free2_tag),
      .free_count     (free_count),
      .overflow_err   (overflow_err)
   );

   always #5 clock = ~clock;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference state: free tags in allocation order, tags held by dispatch, sticky error.
   logic [7:0] fl[$];
   logic [7:0] inflight[$];
   logic       ovf_model;
   logic [7:0] map_tb[32];

   // Last observed dispatch outputs, for directed expectations.
   logic [7:0] obs_t1, obs_t2;
   logic       obs_w1, obs_w2, obs_stall;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      fl.delete();
      for (int i = 1; i <= 32; i++) fl.push_back(8'(i));
      inflight.delete();
      ovf_model = 1'b0;
   endtask

   task automatic drop_inflight(input logic [7:0] t);
      int idx = -1;
      for (int i = 0; i < inflight.size(); i++) if (idx < 0 && inflight[i] == t) idx = i;
      if (idx >= 0) inflight.delete(idx);
   endtask

   task automatic apply_reset();
      @(negedge clock);
      reset          = 1'b1;
      disp1_valid    = 1'($urandom);
      disp1_dest_reg = 5'($urandom);
      disp2_valid    = 1'($urandom);
      disp2_dest_reg = 5'($urandom);
      free1_valid    = 1'($urandom);
      free1_tag      = 8'($urandom_range(1, 32));
      free2_valid    = 1'b0;
      #1;
      check_eq("rst_stall", disp_stall, 1);
      check_eq("rst_w1", mt_write1, 0);
      check_eq("rst_w2", mt_write2, 0);
      check_eq("rst_t1", disp1_tag, 0);
      check_eq("rst_t2", disp2_tag, 0);
      @(posedge clock);
      #1;
      reset = 1'b0;
      model_reset();
      check_eq("rst_count", free_count, 32);
      check_eq("rst_ovf", overflow_err, 0);
   endtask

   task automatic do_cycle(input logic d1v, input logic [4:0] d1r,
                           input logic d2v, input logic [4:0] d2r,
                           input logic f1v, input logic [7:0] f1t,
                           input logic f2v, input logic [7:0] f2t);
      bit         n1, n2, gr, ew1, ew2;
      int         need;
      logic [7:0] e1, e2;
      @(negedge clock);
      disp1_valid = d1v; disp1_dest_reg = d1r;
      disp2_valid = d2v; disp2_dest_reg = d2r;
      free1_valid = f1v; free1_tag = f1t;
      free2_valid = f2v; free2_tag = f2t;
      #1;
      n1   = d1v && (d1r != 5'd31);
      n2   = d2v && (d2r != 5'd31);
      need = int'(n1) + int'(n2);
      gr   = (need <= fl.size());
      e1 = 8'h00; e2 = 8'h00;
      if (gr && n1) e1 = fl.pop_front();
      if (gr && n2) e2 = fl.pop_front();
      ew1 = gr && n1 && !(n2 && d1r == d2r);
      ew2 = gr && n2;
      check_eq("stall", disp_stall, !gr);
      check_eq("tag1", disp1_tag, e1);
      check_eq("tag2", disp2_tag, e2);
      check_eq("mt_w1", mt_write1, ew1);
      check_eq("mt_w2", mt_write2, ew2);
      if (ew1) begin
         check_eq("mt_reg1", mt_reg1, d1r);
         check_eq("mt_tag1", mt_tag1, e1);
      end
      if (ew2) begin
         check_eq("mt_reg2", mt_reg2, d2r);
         check_eq("mt_tag2", mt_tag2, e2);
      end
      if (mt_write1) map_tb[mt_reg1] = mt_tag1;
      if (mt_write2) map_tb[mt_reg2] = mt_tag2;
      obs_t1 = disp1_tag; obs_t2 = disp2_tag;
      obs_w1 = mt_write1; obs_w2 = mt_write2; obs_stall = disp_stall;
      if (e1 != 8'h00) inflight.push_back(e1);
      if (e2 != 8'h00) inflight.push_back(e2);
      // Frees enqueue after this cycle's pops; a full list drops the push.
      if (f1v && f1t != 8'h00) begin
         drop_inflight(f1t);
         if (fl.size() < 32) fl.push_back(f1t); else ovf_model = 1'b1;
      end
      if (f2v && f2t != 8'h00) begin
         drop_inflight(f2t);
         if (fl.size() < 32) fl.push_back(f2t); else ovf_model = 1'b1;
      end
      @(posedge clock);
      #1;
      check_eq("count", free_count, fl.size());
      check_eq("ovf", overflow_err, ovf_model);
   endtask

   task automatic random_cycle(input int free_pct);
      logic       f1v, f2v;
      logic [7:0] f1t, f2t;
      logic [4:0] r1, r2;
      int         idx;
      f1v = 1'b0; f2v = 1'b0; f1t = 8'h00; f2t = 8'h00;
      if (inflight.size() > 0 && $urandom_range(0, 99) < free_pct) begin
         idx = $urandom_range(0, inflight.size() - 1);
         f1v = 1'b1; f1t = inflight[idx];
      end
      if (inflight.size() > 1 && $urandom_range(0, 99) < free_pct) begin
         idx = $urandom_range(0, inflight.size() - 1);
         if (!(f1v && inflight[idx] == f1t)) begin
            f2v = 1'b1; f2t = inflight[idx];
         end
      end
      if ($urandom_range(0, 15) == 0) begin
         f2v = 1'b1; f2t = 8'h00;
      end
      r1 = ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom);
      r2 = ($urandom_range(0, 7) == 0) ? r1 : 5'($urandom);
      do_cycle(1'($urandom), r1, 1'($urandom), r2, f1v, f1t, f2v, f2t);
   endtask

   initial begin
      apply_reset();

      do_cycle(1, 5'd3, 1, 5'd2, 0, 8'h00, 0, 8'h00);
      check_eq("d_r3r2_t1", obs_t1, 8'h01);
      check_eq("d_r3r2_t2", obs_t2, 8'h02);
      check_eq("d_r3r2_w", {obs_w1, obs_w2}, 2'b11);
      check_eq("d_map_r3", map_tb[3], 8'h01);
      check_eq("d_map_r2", map_tb[2], 8'h02);
      check_eq("d_cnt30", free_count, 30);

      do_cycle(1, 5'd5, 1, 5'd5, 0, 8'h00, 0, 8'h00);
      check_eq("d_same_t1", obs_t1, 8'h03);
      check_eq("d_same_t2", obs_t2, 8'h04);
      check_eq("d_same_w", {obs_w1, obs_w2}, 2'b01);
      check_eq("d_map_r5", map_tb[5], 8'h04);

      do_cycle(1, 5'd31, 1, 5'd7, 0, 8'h00, 0, 8'h00);
      check_eq("d_zero_t1", obs_t1, 8'h00);
      check_eq("d_zero_t2", obs_t2, 8'h05);
      check_eq("d_zero_w", {obs_w1, obs_w2}, 2'b01);
      check_eq("d_cnt27", free_count, 27);

      for (int i = 0; i < 13; i++) do_cycle(1, 5'd1, 1, 5'd4, 0, 8'h00, 0, 8'h00);
      check_eq("d_cnt1", free_count, 1);
      do_cycle(1, 5'd8, 1, 5'd9, 1, 8'h01, 0, 8'h00);
      check_eq("d_low_stall", obs_stall, 1);
      check_eq("d_low_cnt", free_count, 2);
      do_cycle(1, 5'd8, 1, 5'd9, 0, 8'h00, 0, 8'h00);
      check_eq("d_low_grant", obs_stall, 0);
      check_eq("d_low_t2", obs_t2, 8'h01);
      check_eq("d_cnt0", free_count, 0);

      for (int i = 0; i < 300; i++) random_cycle(i < 150 ? 30 : 70);
      apply_reset();
      for (int i = 0; i < 300; i++) random_cycle(50);

      for (int i = 0; i < 40 && inflight.size() > 0; i++) begin
         if (inflight.size() > 1)
            do_cycle(0, 5'd0, 0, 5'd0, 1, inflight[0], 1, inflight[1]);
         else
            do_cycle(0, 5'd0, 0, 5'd0, 1, inflight[0], 0, 8'h00);
      end
      check_eq("d_full", free_count, 32);
      do_cycle(0, 5'd0, 0, 5'd0, 1, 8'h05, 0, 8'h00);
      check_eq("d_ovf_set", overflow_err, 1);
      check_eq("d_ovf_cnt", free_count, 32);
      for (int i = 0; i < 4; i++) random_cycle(50);
      check_eq("d_ovf_sticky", overflow_err, 1);
      apply_reset();

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
